// File: rtl/simcomp_pkg.sv
// simcomp_pkg
//   Shared constants and types for the SIMCOMP memory responder: default
//   address/data widths and depth, default wait-state count, the SIMCOMP
//   opcodes that touch memory, and the responder state encoding.
package simcomp_pkg;

  localparam int SIMCOMP_ADDR_W      = 8;
  localparam int SIMCOMP_DATA_W      = 16;
  localparam int SIMCOMP_DEPTH       = 128;
  localparam int SIMCOMP_WAIT_CYCLES = 2;

  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_ADD   = 4'h7;
  localparam logic [3:0] OP_STORE = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } resp_state_t;

  // Index width for a storage of 'depth' words (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/simcomp_mem_array.sv
// simcomp_mem_array
//   DEPTH x DATA_W word store with two synchronous write ports and one
//   asynchronous read port. Contents have no reset. Callers are expected to
//   range-check addresses before asserting a write enable.
// Ports
//   clock    in   rising-edge clock
//   hs_we    in   handshake write enable (higher priority)
//   hs_idx   in   handshake write index
//   hs_data  in   handshake write data
//   pl_we    in   preload write enable (lower priority)
//   pl_idx   in   preload write index
//   pl_data  in   preload write data
//   rd_idx   in   read index
//   rd_data  out  read data (combinational)
module simcomp_mem_array
  import simcomp_pkg::*;
#(
  parameter int DEPTH  = SIMCOMP_DEPTH,
  parameter int DATA_W = SIMCOMP_DATA_W,
  parameter int IDX_W  = idx_width(DEPTH)
) (
  input  logic              clock,
  input  logic              hs_we,
  input  logic [IDX_W-1:0]  hs_idx,
  input  logic [DATA_W-1:0] hs_data,
  input  logic              pl_we,
  input  logic [IDX_W-1:0]  pl_idx,
  input  logic [DATA_W-1:0] pl_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Both ports may write in the same cycle; when they hit the same word the
  // later assignment (handshake) is the one that lands.
  always_ff @(posedge clock) begin
    if (pl_we) mem[pl_idx] <= pl_data;
    if (hs_we) mem[hs_idx] <= hs_data;
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/simcomp_mem_responder.sv
// simcomp_mem_responder
//   Memory-side responder for the SIMCOMP processor. Accepts read/write
//   requests over a four-phase req/ack handshake, inserts WAIT_CYCLES wait
//   states, commits the access on the first edge in RESP, and flags
//   out-of-range addresses. A backdoor preload port writes the store at any
//   time.
// Ports
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset
//   req      in   request level, held until ack is seen
//   we       in   1 = write, 0 = read (sampled with req in IDLE)
//   addr     in   word address (sampled with req in IDLE)
//   wdata    in   write data (sampled with req in IDLE)
//   rdata    out  read data, valid while ack=1 on a read
//   ack      out  response, held until req is sampled low
//   err      out  out-of-range access, valid while ack=1
//   busy     out  high in every state except IDLE
//   pl_en    in   preload write enable
//   pl_addr  in   preload address
//   pl_data  in   preload data
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for req; request fields latched when req is sampled 1
// ST_WAIT | wait-state down-counter running; exits when it reads zero
// ST_RESP | ack=0: commit edge (access + ack<=1); ack=1: hold until req low
module simcomp_mem_responder
  import simcomp_pkg::*;
#(
  parameter int ADDR_W      = SIMCOMP_ADDR_W,
  parameter int DATA_W      = SIMCOMP_DATA_W,
  parameter int DEPTH       = SIMCOMP_DEPTH,
  parameter int WAIT_CYCLES = SIMCOMP_WAIT_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  input  logic              pl_en,
  input  logic [ADDR_W-1:0] pl_addr,
  input  logic [DATA_W-1:0] pl_data
);

  localparam int              IDX_W     = idx_width(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WAIT_LOAD = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  resp_state_t       state;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;

  logic              addr_ok;
  logic              pl_ok;
  logic              commit;
  logic              hs_we;
  logic [DATA_W-1:0] mem_rd;

  // Range checks use the full address width so nothing aliases into the store.
  assign addr_ok = {1'b0, addr_q} < DEPTH_X;
  assign pl_ok   = {1'b0, pl_addr} < DEPTH_X;

  // First edge in RESP is the only one where ack is still low.
  assign commit  = (state == ST_RESP) && !ack;
  assign hs_we   = commit && we_q && addr_ok;

  simcomp_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clock   (clock),
    .hs_we   (hs_we),
    .hs_idx  (addr_q[IDX_W-1:0]),
    .hs_data (wdata_q),
    .pl_we   (pl_en && pl_ok),
    .pl_idx  (pl_addr[IDX_W-1:0]),
    .pl_data (pl_data),
    .rd_idx  (addr_q[IDX_W-1:0]),
    .rd_data (mem_rd)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      rdata    <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            addr_q  <= addr;
            we_q    <= we;
            wdata_q <= wdata;
            busy    <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= ST_RESP;
            end else begin
              wait_cnt <= WAIT_LOAD;
              state    <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          if (wait_cnt == 4'd0) begin
            state <= ST_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        ST_RESP: begin
          if (!ack) begin
            ack <= 1'b1;
            err <= !addr_ok;
            // Out-of-range returns zero; an in-range write leaves rdata alone.
            if (!addr_ok) begin
              rdata <= '0;
            end else if (!we_q) begin
              rdata <= mem_rd;
            end
          end else if (!req) begin
            ack   <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
          ack   <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simcomp_mem_responder.sv
module tb_simcomp_mem_responder;

  logic        clock;
  logic        reset;

  // instance 0: default 2 wait states
  logic        req, we, pl_en;
  logic [7:0]  addr, pl_addr;
  logic [15:0] wdata, pl_data, rdata;
  logic        ack, err, busy;

  // instance 1: zero wait states
  logic        req0, we0, pl_en0;
  logic [7:0]  addr0, pl_addr0;
  logic [15:0] wdata0, pl_data0, rdata0;
  logic        ack0, err0, busy0;

  int total = 0;
  int bad   = 0;

  // reference model: word contents and last returned read data, per instance
  logic [15:0] mdl [2][128];
  logic [15:0] prev_rd [2];

  simcomp_mem_responder dut (
    .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .err(err), .busy(busy),
    .pl_en(pl_en), .pl_addr(pl_addr), .pl_data(pl_data)
  );

  simcomp_mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0),
    .pl_en(pl_en0), .pl_addr(pl_addr0), .pl_data(pl_data0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] exp_rdata(bit sel, logic w, logic [7:0] a);
    if (a >= 8'd128) return 16'h0;
    if (w) return prev_rd[sel];
    return mdl[sel][a[6:0]];
  endfunction

  function automatic void mdl_commit(bit sel, logic w, logic [7:0] a, logic [15:0] d);
    if (a >= 8'd128) prev_rd[sel] = 16'h0;
    else if (w) mdl[sel][a[6:0]] = d;
    else prev_rd[sel] = mdl[sel][a[6:0]];
  endfunction

  task automatic preload(bit sel, logic [7:0] a, logic [15:0] d);
    @(posedge clock); #1;
    if (sel) begin pl_en0 = 1'b1; pl_addr0 = a; pl_data0 = d; end
    else     begin pl_en  = 1'b1; pl_addr  = a; pl_data  = d; end
    @(posedge clock); #1;
    pl_en = 1'b0; pl_en0 = 1'b0;
    if (a < 8'd128) mdl[sel][a[6:0]] = d;
  endtask

  // One full four-phase transaction. lat counts edges from the accepting edge
  // to the edge after which ack is first seen high (bounded at 40).
  task automatic xfer(input bit sel, input logic w, input logic [7:0] a, input logic [15:0] d,
                      output logic [15:0] rd, output logic e, output int lat,
                      output logic ack_rel, output logic busy_rel);
    @(posedge clock); #1;
    if (sel) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else     begin req  = 1'b1; we  = w; addr  = a; wdata  = d; end
    lat = -1;
    do begin
      @(posedge clock); #1;
      lat++;
      if (lat == 0) begin
        // request fields must be ignored once accepted
        if (sel) begin we0 = ~w; addr0 = 8'($urandom); wdata0 = 16'($urandom); end
        else     begin we  = ~w; addr  = 8'($urandom); wdata  = 16'($urandom); end
      end
    end while (!(sel ? ack0 : ack) && lat < 40);
    rd = sel ? rdata0 : rdata;
    e  = sel ? err0 : err;
    if (sel) req0 = 1'b0; else req = 1'b0;
    @(posedge clock); #1;
    ack_rel  = sel ? ack0 : ack;
    busy_rel = sel ? busy0 : busy;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    total++; if (ack !== 1'b0)    begin bad++; $display("FAIL reset_ack got=%b want=0", ack); end
    total++; if (err !== 1'b0)    begin bad++; $display("FAIL reset_err got=%b want=0", err); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0000", rdata); end
    total++; if ({ack0, err0, busy0} !== 3'b000) begin bad++; $display("FAIL reset_flags0 got=%b want=000", {ack0, err0, busy0}); end
    total++; if (rdata0 !== 16'h0) begin bad++; $display("FAIL reset_rdata0 got=%h want=0000", rdata0); end
    reset = 1'b0;
    prev_rd[0] = 16'h0; prev_rd[1] = 16'h0;
  endtask

  task automatic preload_all();
    for (int i = 0; i < 128; i++) begin
      preload(1'b0, 8'(i), 16'($urandom));
      preload(1'b1, 8'(i), 16'($urandom));
    end
  endtask

  task automatic test_basic_read();
    logic [15:0] rd; logic e, ar, br; int lat;
    preload(1'b0, 8'd30, 16'd5);
    preload(1'b0, 8'd31, 16'd8);
    xfer(1'b0, 1'b0, 8'd30, 16'h0, rd, e, lat, ar, br);
    mdl_commit(1'b0, 1'b0, 8'd30, 16'h0);
    total++; if (lat !== 3)      begin bad++; $display("FAIL basic_latency got=%0d want=3", lat); end
    total++; if (rd !== 16'd5)   begin bad++; $display("FAIL basic_rdata got=%h want=0005", rd); end
    total++; if (e !== 1'b0)     begin bad++; $display("FAIL basic_err got=%b want=0", e); end
    total++; if (ar !== 1'b0 || br !== 1'b0) begin bad++; $display("FAIL basic_release got=%b%b want=00", ar, br); end
  endtask

  task automatic test_write_read();
    logic [15:0] rd; logic e, ar, br; int lat;
    xfer(1'b0, 1'b1, 8'd32, 16'h000D, rd, e, lat, ar, br);
    total++; if (rd !== exp_rdata(1'b0, 1'b1, 8'd32)) begin bad++; $display("FAIL wr_rdata_kept got=%h want=%h", rd, exp_rdata(1'b0, 1'b1, 8'd32)); end
    mdl_commit(1'b0, 1'b1, 8'd32, 16'h000D);
    xfer(1'b0, 1'b0, 8'd32, 16'h0, rd, e, lat, ar, br);
    mdl_commit(1'b0, 1'b0, 8'd32, 16'h0);
    total++; if (rd !== 16'h000D) begin bad++; $display("FAIL wr_readback got=%h want=000d", rd); end
    xfer(1'b0, 1'b0, 8'd31, 16'h0, rd, e, lat, ar, br);
    mdl_commit(1'b0, 1'b0, 8'd31, 16'h0);
    total++; if (rd !== 16'd8)    begin bad++; $display("FAIL wr_neighbour got=%h want=0008", rd); end
  endtask

  task automatic test_range();
    logic [15:0] rd; logic e, ar, br; int lat;
    preload(1'b0, 8'd0, 16'h0A0A);
    xfer(1'b0, 1'b1, 8'd128, 16'hFFFF, rd, e, lat, ar, br);
    mdl_commit(1'b0, 1'b1, 8'd128, 16'hFFFF);
    total++; if (e !== 1'b1)    begin bad++; $display("FAIL range_wr_err got=%b want=1", e); end
    total++; if (rd !== 16'h0)  begin bad++; $display("FAIL range_wr_rdata got=%h want=0000", rd); end
    total++; if (ar !== 1'b0)   begin bad++; $display("FAIL range_err_clear got=%b want=0", ar); end
    xfer(1'b0, 1'b0, 8'd0, 16'h0, rd, e, lat, ar, br);
    mdl_commit(1'b0, 1'b0, 8'd0, 16'h0);
    total++; if (rd !== 16'h0A0A) begin bad++; $display("FAIL range_no_alias got=%h want=0a0a", rd); end
    xfer(1'b0, 1'b0, 8'd200, 16'h0, rd, e, lat, ar, br);
    mdl_commit(1'b0, 1'b0, 8'd200, 16'h0);
    total++; if (e !== 1'b1 || rd !== 16'h0) begin bad++; $display("FAIL range_rd got=err%b/%h want=err1/0000", e, rd); end
    total++; if (err !== 1'b0)  begin bad++; $display("FAIL range_err_after got=%b want=0", err); end
  endtask

  task automatic test_hold();
    logic [15:0] rd; logic e, ar, br; int lat;
    preload(1'b0, 8'd70, 16'h1234);
    @(posedge clock); #1;
    req = 1'b1; we = 1'b0; addr = 8'd70;
    lat = 0;
    while (!ack && lat < 40) begin @(posedge clock); #1; lat++; end
    mdl_commit(1'b0, 1'b0, 8'd70, 16'h0);
    total++; if (ack !== 1'b1 || rdata !== 16'h1234) begin bad++; $display("FAIL hold_first got=ack%b/%h want=ack1/1234", ack, rdata); end
    preload(1'b0, 8'd70, 16'hBEEF);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      total++;
      if (ack !== 1'b1 || busy !== 1'b1 || rdata !== prev_rd[0]) begin
        bad++; $display("FAIL hold_cycle%0d got=ack%b busy%b %h want=ack1 busy1 %h", i, ack, busy, rdata, prev_rd[0]);
      end
    end
    req = 1'b0;
    @(posedge clock); #1;
    total++; if (ack !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL hold_drop got=ack%b busy%b want=ack0 busy0", ack, busy); end
    xfer(1'b0, 1'b0, 8'd70, 16'h0, rd, e, lat, ar, br);
    mdl_commit(1'b0, 1'b0, 8'd70, 16'h0);
    total++; if (rd !== 16'hBEEF || lat !== 3) begin bad++; $display("FAIL hold_again got=%h lat%0d want=beef lat3", rd, lat); end
  endtask

  task automatic test_preload_pending();
    int lat;
    @(posedge clock); #1;
    req = 1'b1; we = 1'b0; addr = 8'd60;
    @(posedge clock); #1;
    pl_en = 1'b1; pl_addr = 8'd60; pl_data = 16'h6C6C;
    @(posedge clock); #1;
    pl_en = 1'b0;
    mdl[0][60] = 16'h6C6C;
    lat = 0;
    while (!ack && lat < 40) begin @(posedge clock); #1; lat++; end
    mdl_commit(1'b0, 1'b0, 8'd60, 16'h0);
    total++; if (rdata !== 16'h6C6C) begin bad++; $display("FAIL pending_preload got=%h want=6c6c", rdata); end
    req = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid();
    logic [15:0] rd; logic e, ar, br; int lat;
    preload(1'b0, 8'd40, 16'h1111);
    @(posedge clock); #1;
    req = 1'b1; we = 1'b1; addr = 8'd40; wdata = 16'h2222;
    @(posedge clock); #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy got=%b want=1", busy); end
    @(posedge clock); #1;
    reset = 1'b1; req = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    prev_rd[0] = 16'h0; prev_rd[1] = 16'h0;
    total++; if ({ack, busy, err} !== 3'b000) begin bad++; $display("FAIL rstmid_flags got=%b want=000", {ack, busy, err}); end
    total++; if (rdata !== 16'h0) begin bad++; $display("FAIL rstmid_rdata got=%h want=0000", rdata); end
    repeat (4) @(posedge clock);
    #1;
    xfer(1'b0, 1'b0, 8'd40, 16'h0, rd, e, lat, ar, br);
    mdl_commit(1'b0, 1'b0, 8'd40, 16'h0);
    total++; if (rd !== 16'h1111) begin bad++; $display("FAIL rstmid_dropped got=%h want=1111", rd); end
  endtask

  task automatic test_zero_wait();
    logic [15:0] rd; logic e, ar, br; int lat;
    preload(1'b1, 8'd20, 16'h311E);
    xfer(1'b1, 1'b0, 8'd20, 16'h0, rd, e, lat, ar, br);
    mdl_commit(1'b1, 1'b0, 8'd20, 16'h0);
    total++; if (lat !== 1)         begin bad++; $display("FAIL zw_latency got=%0d want=1", lat); end
    total++; if (rd !== 16'h311E)   begin bad++; $display("FAIL zw_rdata got=%h want=311e", rd); end
    total++; if (ar !== 1'b0 || br !== 1'b0) begin bad++; $display("FAIL zw_release got=%b%b want=00", ar, br); end
    // preload and handshake write land on the same (commit) edge
    @(posedge clock); #1;
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'd50; wdata0 = 16'hABCD;
    @(posedge clock); #1;
    pl_en0 = 1'b1; pl_addr0 = 8'd50; pl_data0 = 16'h5555;
    @(posedge clock); #1;
    pl_en0 = 1'b0;
    total++; if (ack0 !== 1'b1) begin bad++; $display("FAIL zw_same_edge_ack got=%b want=1", ack0); end
    req0 = 1'b0;
    @(posedge clock); #1;
    mdl[1][50] = 16'h5555;
    mdl_commit(1'b1, 1'b1, 8'd50, 16'hABCD);
    xfer(1'b1, 1'b0, 8'd50, 16'h0, rd, e, lat, ar, br);
    mdl_commit(1'b1, 1'b0, 8'd50, 16'h0);
    total++; if (rd !== 16'hABCD) begin bad++; $display("FAIL zw_hs_wins got=%h want=abcd", rd); end
  endtask

  task automatic test_random(bit sel, int n);
    logic [15:0] rd, d, xr; logic e, ar, br, w; logic [7:0] a; int lat;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0)
        preload(sel, 8'($urandom_range(0, 255)), 16'($urandom));
      w = 1'($urandom);
      a = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(128, 255)) : 8'($urandom_range(0, 127));
      d = 16'($urandom);
      xr = exp_rdata(sel, w, a);
      xfer(sel, w, a, d, rd, e, lat, ar, br);
      mdl_commit(sel, w, a, d);
      total++; if (lat !== (sel ? 1 : 3)) begin bad++; $display("FAIL rnd%0d_%0d_latency got=%0d want=%0d", sel, i, lat, sel ? 1 : 3); end
      total++; if (rd !== xr) begin bad++; $display("FAIL rnd%0d_%0d_rdata a=%0d we=%b got=%h want=%h", sel, i, a, w, rd, xr); end
      total++; if (e !== (a >= 8'd128)) begin bad++; $display("FAIL rnd%0d_%0d_err a=%0d got=%b want=%b", sel, i, a, e, a >= 8'd128); end
      total++; if (ar !== 1'b0 || br !== 1'b0) begin bad++; $display("FAIL rnd%0d_%0d_release got=%b%b want=00", sel, i, ar, br); end
    end
  endtask

  initial begin
    reset = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; pl_en0 = 1'b0; pl_addr0 = '0; pl_data0 = '0;
    test_reset();
    preload_all();
    test_basic_read();
    test_write_read();
    test_range();
    test_hold();
    test_preload_pending();
    test_reset_mid();
    test_zero_wait();
    test_random(1'b0, 40);
    test_random(1'b1, 15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
